if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction fetch stage feeding the ID stage decoder. It generates the PC, issues word reads to instruction memory over a req/ack handshake and buffers the returned 16-bit instructions in a small prefetch FIFO. It presents them, with their PCs, to ID on a valid/ready interface. A redirect input (branch or jump resolved downstream) flushes the buffer and restarts fetch at a new address.

## Interface
- ADDR_W, 16, PC and memory word-address width.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 0, first fetch address after reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request; registered.
- imem_addr  out  ADDR_W  word address; stable while imem_req=1 until ack.
- imem_ack  in  1  request completed; imem_rdata valid in this cycle.
- imem_rdata  in  16  instruction word.
- id_valid  out  1  FIFO head holds a valid instruction.
- id_instr  out  16  head instruction (opcode in [15:12]); 0 when id_valid=0.
- id_pc  out  ADDR_W  PC of head instruction; 0 when id_valid=0.
- id_ready  in  1  ID accepts head this cycle.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  restart address, sampled when redirect=1.

## Operation
- Registers: fetch_pc, FIFO of {pc, instr} with occupancy counter, and a 3-state FSM.
- The FSM has three states: IDLE, REQ and DROP.
- imem_req=1 in REQ and DROP. imem_addr = fetch_pc in IDLE and REQ; it holds the in-flight address in DROP.
- At most one request is outstanding. A transfer completes on the cycle imem_ack=1 while imem_req=1. Ack may arrive in the first req cycle. Ack while imem_req=0 is ignored.
- Define occ_next = occ + push - pop.
- IDLE: go to REQ when occ_next < DEPTH.
- REQ, ack without redirect:
  - push {fetch_pc, imem_rdata} and set fetch_pc = fetch_pc+1, wrapping modulo 2^ADDR_W.
  - Stay in REQ if occ_next < DEPTH, else go to IDLE.
- REQ, no ack: hold.
- Pop occurs when id_valid && id_ready, with no redirect in that cycle.
- Push and pop may occur in the same cycle; occupancy is then unchanged.
- Redirect has priority over push, pop and the normal FSM transitions:
  - The FIFO is emptied and fetch_pc = redirect_pc.
  - A concurrent pop is void, and a concurrent ack's data is discarded.
  - In REQ without ack, go to DROP and record the in-flight address for imem_addr.
  - In REQ with ack, or in IDLE, go to REQ.
  - In DROP, stay in DROP; fetch_pc still updates.
- DROP: hold imem_req and the old address until ack. Discard the returned data and do not push. On ack, go to REQ, whose address is then fetch_pc.
- The FIFO never overflows, because a request is only issued when a slot is guaranteed free.

## Timing
- While rst=1: FSM=IDLE, fetch_pc=RESET_PC, occ=0, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
- Reset asserted mid-transfer clears everything immediately. Any in-flight ack is ignored.
- First clock edge after rst falls: IDLE -> REQ, so imem_req=1 with imem_addr=RESET_PC.
- Ack in cycle n -> id_valid=1 with that instruction in cycle n+1.
- Ack in cycle n -> next request address on imem_addr in cycle n+1.
- Throughput is one instruction per cycle when ack is returned in the same cycle as the request.
- Redirect in cycle n -> id_valid=0 in cycle n+1. The first instruction from redirect_pc appears one cycle after its ack.
- id_valid/id_instr/id_pc are combinational from FIFO head registers. They change only on clock edges.

## Test plan
- Reset and first fetch:
  - Stimulus: release rst, ack immediately with rdata 0x1234.
  - Required response: imem_req=1, addr 0x0000 one cycle after release. Next cycle id_valid=1, id_instr=0x1234, id_pc=0x0000.
- Streaming:
  - Stimulus: ack every cycle, rdata = addr ^ 0xA000, id_ready=1.
  - Required response: ID receives pc 0,1,2,... with instr 0xA000,0xA001,... one per cycle with no gaps.
- Backpressure:
  - Stimulus: id_ready=0, ack always.
  - Required response: exactly 4 fetches (addr 0..3). imem_req then drops; id_pc holds 0x0000.
  - Then raise id_ready: fetch resumes at addr 4 and order is preserved.
- Redirect during pending request:
  - Stimulus: request at addr 2 with ack delayed 3 cycles; redirect to 0x0100 in the first wait cycle.
  - Required response: imem_addr stays 2 until ack and that data is never presented. id_valid=0 next cycle. Next request is addr 0x0100, and the first id_pc is 0x0100.
- Redirect coincident with ack and pop:
  - Stimulus: redirect=1, imem_ack=1, id_ready=1 in the same cycle, redirect_pc=0x0200.
  - Required response: the ack data is dropped and DROP is not entered. The next cycle requests 0x0200, and occupancy is 0.
- PC wrap and async reset:
  - Stimulus: redirect to 0xFFFF.
  - Required response: id_pc 0xFFFF then 0x0000.
  - Stimulus: assert rst between clock edges.
  - Required response: imem_req and id_valid go to 0 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding imem read handshake,
// and a small prefetch FIFO presenting {pc, instr} to ID on a valid/ready interface.
module if_fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              id_valid,
    output logic [15:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);
    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam int unsigned      OCC_W   = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] drop_addr;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_next;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [15:0]       instr_q [DEPTH];
    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic              xfer;
    logic              push;
    logic              pop;
    logic              has_room;

    assign xfer     = imem_req & imem_ack;
    assign push     = xfer & (state == REQ) & ~redirect;
    assign pop      = id_valid & id_ready & ~redirect;
    assign occ_next = occ + OCC_W'(push) - OCC_W'(pop);
    assign has_room = occ_next < DEPTH_V;

    // While dropping, the address of the abandoned request must stay on the bus.
    assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;

    always_comb begin
        id_valid = (occ != '0);
        id_instr = '0;
        id_pc    = '0;
        if (id_valid) begin
            id_instr = instr_q[rd_ptr];
            id_pc    = pc_q[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            occ       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            imem_req <= 1'b1;
            // A request still in flight must be completed and its data discarded.
            if (imem_req && !imem_ack) begin
                state <= DROP;
                if (state == REQ) begin
                    drop_addr <= fetch_pc;
                end
            end else begin
                state <= REQ;
            end
        end else begin
            occ <= occ_next;
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (has_room) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (xfer && !has_room) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                DROP: begin
                    if (xfer) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
